// File: rtl/dense_pkg.sv
// Shared types and parameter defaults for the dense-layer classification stage.
package dense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DATA_W_DEF    = 16;
  localparam int N_CLASSES_DEF = 10;
  localparam int IDX_W_DEF     = 4;

endpackage

// File: rtl/argmax_cmp.sv
// Argmax compare: take a sample when it is the first of the frame or strictly beats the running max.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ties return 0, so the earlier index is kept.
module argmax_cmp #(
  parameter int DATA_W = dense_pkg::DATA_W_DEF
) (
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] max_r,
  input  logic              first,
  output logic              take
);

  assign take = first | ($signed(in_data) > $signed(max_r));

endmodule

// File: rtl/dense_argmax.sv
// Running argmax over N_CLASSES signed scores; reports winning index (and score with DENSE_ARGMAX_SCORE_EN).
// Latency: done one cycle after the last sample, result registers valid the cycle after done.
// Backpressure: none; one sample per in_valid is accepted every cycle while collecting.
module dense_argmax
  import dense_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_score
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  state_t              state, state_nx;
  logic [IDX_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx_r;
  logic [DATA_W-1:0]   max_r;
  logic                take;
  logic                accept;

  assign accept = (state == ST_COLLECT) && in_valid;

  argmax_cmp #(.DATA_W(DATA_W)) u_cmp (
    .in_data (in_data),
    .max_r   (max_r),
    .first   (cnt == '0),
    .take    (take)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_ARM;
      ST_ARM:     state_nx = ST_COLLECT;
      ST_COLLECT: if (in_valid && (cnt == LAST_IDX)) state_nx = ST_DONE;
      ST_DONE:    state_nx = start ? ST_ARM : ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      idx_r     <= '0;
      max_r     <= '0;
      class_idx <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ST_ARM) || (state_nx == ST_COLLECT);
      done  <= (state_nx == ST_DONE);
      if (state == ST_ARM) begin
        cnt   <= '0;
        max_r <= '0;
      end
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (take) begin
          max_r <= in_data;
          idx_r <= cnt;
        end
      end
      if (state == ST_DONE) class_idx <= idx_r;
    end
  end

`ifdef DENSE_ARGMAX_SCORE_EN
  logic [DATA_W-1:0] class_score_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   class_score_r <= '0;
    else if (state == ST_DONE) class_score_r <= max_r;
  end

  assign class_score = class_score_r;
`else
  assign class_score = '0;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Directed bench for dense_argmax: frames with hand-computed argmax results, ignored inputs and mid-frame reset.
module tb_dense_argmax;

`ifdef DENSE_ARGMAX_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic        done;
  logic [3:0]  class_idx;
  logic [15:0] class_score;

  int checks = 0;
  int errors = 0;

  logic [15:0] sc [10];

  always #5 clk = ~clk;

  dense_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .busy        (busy),
    .done        (done),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_sc(input logic [15:0] v);
    return SCORE_EN ? v : 16'h0000;
  endfunction

  // Runs one full frame from sc[]; noise adds ignored in_valid/start pulses.
  task automatic run_frame(input string tag, input logic [3:0] eidx, input logic [15:0] escore,
                           input int maxgap, input bit noise);
    if (noise) begin
      in_valid = 1'b1; in_data = 16'h7fff;
      tick();
      in_valid = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_arm"}, busy, 1);
    if (noise) begin
      in_valid = 1'b1; in_data = 16'h7fff;
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = sc[i];
      start    = noise && (i == 4);
      if (i == 9) chk({tag, "_done_early"}, done, 0);
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    if (noise) begin
      in_valid = 1'b1; in_data = 16'h7fff;
    end
    tick();
    in_valid = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idx"}, class_idx, eidx);
    chk({tag, "_score"}, class_score, exp_sc(escore));
    tick();
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_score", class_score, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    sc = '{16'd3, -16'd5, 16'd7, 16'd2, 16'd0, 16'd1, 16'd7, -16'd1, 16'd4, 16'd6};
    run_frame("basic", 4'd2, 16'd7, 0, 1'b0);

    sc = '{-16'd9, -16'd3, -16'd8, -16'd4, -16'd20, -16'd3, -16'd7, -16'd6, -16'd5, -16'd10};
    run_frame("neg", 4'd1, -16'd3, 3, 1'b0);

    for (int i = 0; i < 9; i++) sc[i] = 16'h8000;
    sc[9] = 16'h7fff;
    run_frame("last", 4'd9, 16'h7fff, 0, 1'b0);

    for (int i = 0; i < 10; i++) sc[i] = 16'h8000;
    run_frame("allmin", 4'd0, 16'h8000, 1, 1'b0);

    sc = '{16'd3, -16'd5, 16'd7, 16'd2, 16'd0, 16'd1, 16'd7, -16'd1, 16'd4, 16'd6};
    run_frame("noise", 4'd2, 16'd7, 0, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("hold_idx", class_idx, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'd100;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_idx", class_idx, 0);
    chk("midrst_score", class_score, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_done", done, 0);

    sc = '{16'd3, -16'd5, 16'd7, 16'd2, 16'd0, 16'd1, 16'd7, -16'd1, 16'd4, 16'd6};
    run_frame("after_rst", 4'd2, 16'd7, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
